// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryption core.
// Performs one full cipher round per clock using an externally supplied,
// flattened round-key schedule. One block in flight at a time.
`timescale 1ns/1ps

module aes_cipher_iter #(
    parameter  int Nk = 4,
    localparam int Nr = Nk + 6,
    localparam int RW = $clog2(Nr + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [128*(Nr+1)-1:0]  k_sch,
    input  logic [127:0]           in_block,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [127:0]           out_block,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [RW-1:0] LAST_ROUND = RW'(Nr);
    localparam logic [RW-1:0] ROUND_ONE  = RW'(1);

    // GF(2^8) multiply by x, reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) general multiply (shift-and-add)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = b;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Forward S-box: field inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // MixColumns on one column; row 0 byte sits in bits [7:0]
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

    fsm_e            fsm_q;
    logic [RW-1:0]   round_q;
    logic [127:0]    state_q;
    logic [127:0]    out_block_q;
    logic            out_valid_q;
    logic            in_ready_q;

    logic [127:0]    sub_bytes;
    logic [127:0]    shift_rows;
    logic [127:0]    mix_cols;
    logic [127:0]    round_key;
    logic [127:0]    mid_state_d;
    logic [127:0]    final_state_d;

    // Sixteen parallel S-boxes for the round datapath
    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign sub_bytes[8*n +: 8] = sbox(state_q[8*n +: 8]);
    end

    // ShiftRows: row r rotates left by r columns
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shift_rows[8*(4*c+r) +: 8] = sub_bytes[8*(4*((c+r)%4)+r) +: 8];
        end
        assign mix_cols[32*c +: 32] = mix_column(shift_rows[32*c +: 32]);
    end

    // Round-key select and next-state candidates for normal and final rounds
    always_comb begin
        round_key     = k_sch[{round_q, 7'b0} +: 128];
        mid_state_d   = mix_cols ^ round_key;
        final_state_d = shift_rows ^ round_key;
    end

    // Control FSM, round counter, cipher state and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            state_q     <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= in_block ^ k_sch[127:0];
                        round_q    <= ROUND_ONE;
                        in_ready_q <= 1'b0;
                        fsm_q      <= RUN;
                    end else begin
                        fsm_q      <= IDLE;
                    end
                end
                RUN: begin
                    if (round_q < LAST_ROUND) begin
                        state_q <= mid_state_d;
                        round_q <= round_q + ROUND_ONE;
                    end else begin
                        state_q     <= final_state_d;
                        out_block_q <= final_state_d;
                        out_valid_q <= 1'b1;
                        round_q     <= '0;
                        fsm_q       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end else begin
                        fsm_q       <= DONE;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    round_q     <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed testbench for aes_cipher_iter: FIPS-197 vectors for Nk=4/6/8,
// backpressure, ignored inputs, mid-block reset and back-to-back blocks.
`timescale 1ns/1ps

module tb_aes_cipher_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic [128*11-1:0] k4;
    logic [128*13-1:0] k6;
    logic [128*15-1:0] k8;
    logic [127:0] ib4, ib6, ib8, ob4, ob6, ob8;
    logic iv4, iv6, iv8, ir4, ir6, ir8, ov4, ov6, ov8, or4, or6, or8;

    int total = 0;
    int bad   = 0;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_cipher_iter #(.Nk(4)) u4 (
        .clk(clk), .rst_n(rst_n), .k_sch(k4), .in_block(ib4), .in_valid(iv4),
        .in_ready(ir4), .out_block(ob4), .out_valid(ov4), .out_ready(or4)
    );
    aes_cipher_iter #(.Nk(6)) u6 (
        .clk(clk), .rst_n(rst_n), .k_sch(k6), .in_block(ib6), .in_valid(iv6),
        .in_ready(ir6), .out_block(ob6), .out_valid(ov6), .out_ready(or6)
    );
    aes_cipher_iter #(.Nk(8)) u8 (
        .clk(clk), .rst_n(rst_n), .k_sch(k8), .in_block(ib8), .in_valid(iv8),
        .in_ready(ir8), .out_block(ob8), .out_valid(ov8), .out_ready(or8)
    );

    function automatic logic [7:0] sb(input logic [7:0] v);
        return SBOX_TBL[2047 - 8*int'(v) -: 8];
    endfunction

    // FIPS hex strings put the first byte in the MSBs; the bus puts it in [7:0]
    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = x[8*(15-n) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] seqkey(input int nbytes);
        logic [255:0] k;
        k = '0;
        for (int n = 0; n < nbytes; n++) k[8*n +: 8] = 8'(n);
        return k;
    endfunction

    // FIPS-197 key expansion, byte-oriented
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [7:0] w [60][4];
        logic [7:0] t [4];
        logic [7:0] rc;
        logic [7:0] tmp;
        logic [1919:0] r;
        r  = '0;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) for (int j = 0; j < 4; j++) w[i][j] = 8'h00;
        for (int i = 0; i < nk; i++) for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
        for (int i = nk; i < 4*(nk+7); i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % nk == 0) begin
                tmp  = t[0];
                t[0] = sb(t[1]) ^ rc;
                t[1] = sb(t[2]);
                t[2] = sb(t[3]);
                t[3] = sb(tmp);
                rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sb(t[j]);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
        end
        for (int i = 0; i < 4*(nk+7); i++) for (int j = 0; j < 4; j++) r[8*(4*i+j) +: 8] = w[i][j];
        return r;
    endfunction

    logic [127:0]  pt_c, ct_c1, ct_c2, ct_c3, pt_b, ct_b;
    logic [1919:0] ks_c1, ks_b, ks_c2, ks_c3;

    task automatic start(input int sel);
        case (sel)
            4: iv4 = 1'b1;
            6: iv6 = 1'b1;
            default: iv8 = 1'b1;
        endcase
        @(posedge clk); #1;
        iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
    endtask

    task automatic wait_valid(input int sel, output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if ((sel == 4 && ov4) || (sel == 6 && ov6) || (sel == 8 && ov8)) break;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
        or4 = 1'b1; or6 = 1'b1; or8 = 1'b1;
        ib4 = '0; ib6 = '0; ib8 = '0;
        k4 = '0; k6 = '0; k8 = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", ir4); end
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", ov4); end
        total++; if (ob4 !== 128'h0) begin bad++; $display("FAIL reset_out_block: got %h want 0", ob4); end
        total++; if ({ir6, ov6, ir8, ov8} !== 4'b1010) begin bad++; $display("FAIL reset_nk68: got %b want 1010", {ir6, ov6, ir8, ov8}); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", ir4); end
    endtask

    task automatic test_c1();
        int cyc;
        k4 = ks_c1[128*11-1:0]; ib4 = pt_c; or4 = 1'b1;
        start(4);
        wait_valid(4, cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL c1_latency: got %0d want 10", cyc); end
        total++; if (ob4 !== ct_c1) begin bad++; $display("FAIL c1_block: got %h want %h", ob4, ct_c1); end
        @(posedge clk); #1;
        total++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin bad++; $display("FAIL c1_return_idle: got ready=%b valid=%b want 1 0", ir4, ov4); end
    endtask

    task automatic test_backpressure();
        int cyc;
        k4 = ks_b[128*11-1:0]; ib4 = pt_b; or4 = 1'b0;
        start(4);
        wait_valid(4, cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL appb_latency: got %0d want 10", cyc); end
        total++; if (ob4 !== ct_b) begin bad++; $display("FAIL appb_block: got %h want %h", ob4, ct_b); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (ov4 !== 1'b1 || ob4 !== ct_b) begin
                bad++; $display("FAIL appb_hold%0d: got valid=%b block=%h want 1 %h", i, ov4, ob4, ct_b);
            end
        end
        or4 = 1'b1;
        @(posedge clk); #1;
        total++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin bad++; $display("FAIL appb_release: got valid=%b ready=%b want 0 1", ov4, ir4); end
        @(posedge clk); #1;
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL appb_single_transfer: got valid=%b want 0", ov4); end
    endtask

    task automatic test_nk6_nk8();
        int cyc;
        k6 = ks_c2[128*13-1:0]; ib6 = pt_c; or6 = 1'b1;
        start(6);
        wait_valid(6, cyc);
        total++; if (cyc != 12) begin bad++; $display("FAIL c2_latency: got %0d want 12", cyc); end
        total++; if (ob6 !== ct_c2) begin bad++; $display("FAIL c2_block: got %h want %h", ob6, ct_c2); end
        @(posedge clk); #1;
        k8 = ks_c3; ib8 = pt_c; or8 = 1'b1;
        start(8);
        wait_valid(8, cyc);
        total++; if (cyc != 14) begin bad++; $display("FAIL c3_latency: got %0d want 14", cyc); end
        total++; if (ob8 !== ct_c3) begin bad++; $display("FAIL c3_block: got %h want %h", ob8, ct_c3); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_input();
        int cyc;
        k4 = ks_c1[128*11-1:0]; ib4 = pt_c; or4 = 1'b0;
        start(4);
        iv4 = 1'b1; ib4 = pt_b;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL ign_run_ready: got %b want 0", ir4); end
            if (ov4) break;
        end
        total++; if (cyc != 10) begin bad++; $display("FAIL ign_latency: got %0d want 10", cyc); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (ir4 !== 1'b0 || ov4 !== 1'b1 || ob4 !== ct_c1) begin
                bad++; $display("FAIL ign_done%0d: got ready=%b valid=%b block=%h want 0 1 %h", i, ir4, ov4, ob4, ct_c1);
            end
        end
        iv4 = 1'b0; or4 = 1'b1;
        @(posedge clk); #1;
        total++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin bad++; $display("FAIL ign_release: got ready=%b valid=%b want 1 0", ir4, ov4); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        k4 = ks_c1[128*11-1:0]; ib4 = pt_c; or4 = 1'b1;
        start(4);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (ov4 !== 1'b0 || ob4 !== 128'h0 || ir4 !== 1'b1) begin
            bad++; $display("FAIL midrst_async: got valid=%b block=%h ready=%b want 0 0 1", ov4, ob4, ir4);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start(4);
        wait_valid(4, cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL midrst_latency: got %0d want 10", cyc); end
        total++; if (ob4 !== ct_c1) begin bad++; $display("FAIL midrst_block: got %h want %h", ob4, ct_c1); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [127:0]  pts [3];
        logic [127:0]  cts [3];
        logic [1407:0] kss [3];
        int acc_t [4];
        int acc_n, xfer_n;
        logic pre_ir, pre_iv, pre_ov;
        logic [127:0] pre_ob;
        pts[0] = pt_c;  pts[1] = pt_b;  pts[2] = pt_c;
        cts[0] = ct_c1; cts[1] = ct_b;  cts[2] = ct_c1;
        kss[0] = ks_c1[1407:0]; kss[1] = ks_b[1407:0]; kss[2] = ks_c1[1407:0];
        for (int i = 0; i < 4; i++) acc_t[i] = 0;
        acc_n = 0; xfer_n = 0;
        ib4 = pts[0]; k4 = kss[0]; or4 = 1'b1; iv4 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            pre_ir = ir4; pre_iv = iv4; pre_ov = ov4; pre_ob = ob4;
            @(posedge clk); #1;
            if (pre_ir && pre_iv) begin
                if (acc_n < 4) acc_t[acc_n] = c;
                acc_n++;
            end
            if (pre_ov) begin
                if (xfer_n < 3) begin
                    total++;
                    if (pre_ob !== cts[xfer_n]) begin
                        bad++; $display("FAIL b2b_block%0d: got %h want %h", xfer_n, pre_ob, cts[xfer_n]);
                    end
                end
                xfer_n++;
                if (xfer_n < 3) begin
                    ib4 = pts[xfer_n]; k4 = kss[xfer_n];
                end else begin
                    iv4 = 1'b0;
                end
            end
        end
        iv4 = 1'b0;
        total++; if (acc_n != 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", acc_n); end
        total++; if (xfer_n != 3) begin bad++; $display("FAIL b2b_transfers: got %0d want 3", xfer_n); end
        total++; if (acc_t[1] - acc_t[0] != 12) begin bad++; $display("FAIL b2b_gap01: got %0d want 12", acc_t[1] - acc_t[0]); end
        total++; if (acc_t[2] - acc_t[1] != 12) begin bad++; $display("FAIL b2b_gap12: got %0d want 12", acc_t[2] - acc_t[1]); end
    endtask

    initial begin
        pt_c  = bswap(128'h00112233445566778899aabbccddeeff);
        ct_c1 = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        ct_c2 = bswap(128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        ct_c3 = bswap(128'h8ea2b7ca516745bfeafc49904b496089);
        pt_b  = bswap(128'h3243f6a8885a308d313198a2e0370734);
        ct_b  = bswap(128'h3925841d02dc09fbdc118597196a0b32);
        ks_c1 = expand(seqkey(16), 4);
        ks_c2 = expand(seqkey(24), 6);
        ks_c3 = expand(seqkey(32), 8);
        ks_b  = expand({128'h0, bswap(128'h2b7e151628aed2a6abf7158809cf4f3c)}, 4);

        test_reset();
        test_c1();
        test_backpressure();
        test_nk6_nk8();
        test_ignore_input();
        test_reset_mid();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
